regfile_dump_reader: RTL

- Read-side sequencer for the 8-bit register file.
- On a start request, walks a programmed address range through the file's combinational read port and streams each word out over a valid/ready byte interface.
- Typical sinks: the debug UART transmitter, monitor ROM status port.
- Runs one range per request; range may wrap past the top address.

---
 rtl/regfile_dump_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// Purpose: walks a latched register-file address range (wrapping past the top) and streams each word out.
// Latency: start in cycle N gives the first valid beat in N+2; one word every 2 cycles with outReady held high.
// Backpressure: outData/outValid hold while outReady is low, with no limit on stall length; abort cancels the dump.
// Optional: define REGDUMP_ADDR_TAG_EN to precede every data beat with a beat carrying its address.
module regfile_dump_reader #(
    parameter int DataWidth  = 8,
    parameter int NumRegs    = 16,
    parameter int IndexWidth = $clog2(NumRegs)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IndexWidth-1:0] firstAddr,
    input  logic [IndexWidth-1:0] lastAddr,
    output logic [IndexWidth-1:0] rfReadAddr,
    input  logic [DataWidth-1:0]  rfReadData,
    output logic [DataWidth-1:0]  outData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  busy,
    output logic                  done
);

`ifdef REGDUMP_ADDR_TAG_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TAG   = 2'd1,
        S_FETCH = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    // Each word begins with its address tag.
    localparam state_t WordStart = S_TAG;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    // Each word begins directly with the read of the register file.
    localparam state_t WordStart = S_FETCH;
`endif

    localparam logic [IndexWidth-1:0] TopAddr = IndexWidth'(NumRegs - 1);

    state_t                state_q, state_d;
    logic [IndexWidth-1:0] addr_q, addr_d;
    logic [IndexWidth-1:0] last_q, last_d;
    logic [DataWidth-1:0]  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [IndexWidth-1:0] addr_next;

    // Address increment modulo NumRegs, so non-power-of-2 files wrap to 0 after the top register.
    always_comb begin
        addr_next = addr_q + 1'b1;
        if (addr_q == TopAddr) begin
            addr_next = '0;
        end
    end

    // Next-state and registered-output computation; abort overrides everything outside IDLE.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort in IDLE suppresses a coincident start
                if (start && !abort) begin
                    addr_d  = firstAddr;
                    last_d  = lastAddr;
                    busy_d  = 1'b1;
                    state_d = WordStart;
                end
            end
`ifdef REGDUMP_ADDR_TAG_EN
            S_TAG: begin
                // First cycle presents the tag; later cycles wait for it to be taken.
                if (!out_valid_q) begin
                    out_data_d  = DataWidth'(addr_q);
                    out_valid_d = 1'b1;
                end else if (outReady) begin
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end
`endif
            S_FETCH: begin
                // rfReadAddr already shows addr_q, so the read data is valid this cycle.
                out_data_d  = rfReadData;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    if (addr_q == last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_next;
                        state_d = WordStart;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase

        // A beat accepted in the abort cycle has already been delivered; nothing more follows.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rfReadAddr = addr_q;
    assign outData    = out_data_q;
    assign outValid   = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
